// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared state encoding, default sizing and helpers for the
// FIFO burst scheduler and its round-robin arbiter.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } sched_state_e;

  localparam int READY_NUM_DEF = 514;
  localparam int BURST_LEN_DEF = 512;
  localparam int CNT_W_DEF     = 11;

  // Width of an encoded channel index; a single channel still needs one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/fifo_burst_scheduler_if.sv
// fifo_burst_scheduler_if: FIFO-side, engine-handshake and stream signals of the
// burst scheduler; master = scheduler, slave = FIFOs plus page-write engine.
interface fifo_burst_scheduler_if
  import fifo_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DATA_W = 16
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH*CNT_W-1:0]  fifo_num;
  logic [NUM_CH*DATA_W-1:0] fifo_dout;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic                     burst_req;
  logic [CH_W-1:0]          burst_ch;
  logic                     burst_ack;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     burst_done;
  logic                     burst_abort;

  modport master (
    input  fifo_num, fifo_dout, burst_ack,
    output fifo_rd_en, burst_req, burst_ch, out_data, out_valid, out_last,
           burst_done, burst_abort
  );

  modport slave (
    output fifo_num, fifo_dout, burst_ack,
    input  fifo_rd_en, burst_req, burst_ch, out_data, out_valid, out_last,
           burst_done, burst_abort
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; the search starts one past ptr
// and the nearest requesting channel wins.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IW     = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant = '0;
    idx   = '0;
    cand  = '0;
    if (en) begin
      // Walk farthest-to-nearest so the nearest requester is written last.
      for (int off = NUM_CH; off >= 1; off--) begin
        cand = IW'((int'(ptr) + off) % NUM_CH);
        if (req[cand]) begin
          grant       = '0;
          grant[cand] = 1'b1;
          idx         = cand;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_burst_scheduler.sv
// fifo_burst_scheduler: shares one page-write engine between NUM_CH channel FIFOs,
// draining BURST_LEN words per grant. Define FIFO_SCHED_TIMEOUT_EN for the REQ timeout.
module fifo_burst_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DATA_W    = 16,
  parameter int READY_NUM = READY_NUM_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int TIMEOUT   = 1024
) (
  input logic                    clk,
  input logic                    reset,
  fifo_burst_scheduler_if.master bus
);

  localparam int CH_W = ch_idx_w(NUM_CH);
  localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0]  LAST_CNT  = BC_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] READY_THR = CNT_W'(READY_NUM);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_REQ   = REQ;
  localparam logic [1:0] S_XFER  = XFER;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]        state;
  logic [NUM_CH-1:0] ready_q;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   ch_q;
  logic [BC_W-1:0]   word_cnt;
  logic              rd_active;
  logic              valid_q;
  logic              last_q;
  logic              done_q;
  logic              tmo_hit;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IW     (CH_W)
  ) u_arb (
    .req   (ready_q),
    .ptr   (rr_ptr),
    .en    (state == S_IDLE),
    .grant (grant),
    .idx   (grant_idx)
  );

`ifdef FIFO_SCHED_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             abort_q;

  // Counter is zero on the first REQ cycle, so the abort lands TIMEOUT cycles after burst_req rises.
  assign tmo_hit = (state == S_REQ) && !bus.burst_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= tmo_hit;
      tmo_cnt <= ((state == S_REQ) && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
    end
  end

  assign bus.burst_abort = abort_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.burst_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state    <= S_IDLE;
      ready_q  <= '0;
      rr_ptr   <= '0;
      ch_q     <= '0;
      word_cnt <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Eligibility lags the fill count by a cycle; the READY_NUM margin absorbs it.
      for (int i = 0; i < NUM_CH; i++) begin
        ready_q[i] <= (bus.fifo_num[i*CNT_W +: CNT_W] >= READY_THR);
      end
      valid_q <= rd_active;
      last_q  <= rd_active && (word_cnt == LAST_CNT);
      done_q  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (|grant) begin
            ch_q  <= grant_idx;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.burst_ack) begin
            word_cnt <= '0;
            state    <= S_XFER;
          end else if (tmo_hit) begin
            rr_ptr <= ch_q;
            state  <= S_IDLE;
          end
        end
        S_XFER: begin
          if (word_cnt == LAST_CNT) begin
            state <= S_DRAIN;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          done_q   <= 1'b1;
          rr_ptr   <= ch_q;
          word_cnt <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_active = (state == S_XFER);

  always_comb begin
    bus.fifo_rd_en = '0;
    if (rd_active) bus.fifo_rd_en[ch_q] = 1'b1;
  end

  // The FIFO output register holds the word read on the previous cycle; the
  // select is the registered grant, so out_data lines up with out_valid.
  assign bus.out_data   = valid_q ? bus.fifo_dout[ch_q*DATA_W +: DATA_W] : '0;
  assign bus.out_valid  = valid_q;
  assign bus.out_last   = last_q;
  assign bus.burst_done = done_q;
  assign bus.burst_req  = (state == S_REQ);
  assign bus.burst_ch   = ch_q;

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// tb_fifo_burst_scheduler: table-driven eligibility/arbitration vectors plus
// directed burst, round-robin, data, reset and (with FIFO_SCHED_TIMEOUT_EN) timeout sequences.
module tb_fifo_burst_scheduler;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 11;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 512;
  localparam int TIMEOUT   = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  fifo_burst_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

  fifo_burst_scheduler #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DATA_W    (DATA_W),
    .READY_NUM (514),
    .BURST_LEN (BURST_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // FIFO contents: channel 3 counts from 0x0000, channel c<3 from (c+1)<<12.
  function automatic logic [15:0] word_of(input int ch, input logic [15:0] cnt);
    return (ch == 3) ? cnt : (16'((ch + 1) << 12) | cnt);
  endfunction

  logic [15:0] rd_cnt [NUM_CH];

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        rd_cnt[i] <= '0;
      end else if (bus.fifo_rd_en[i]) begin
        bus.fifo_dout[i*DATA_W +: DATA_W] <= word_of(i, rd_cnt[i]);
        rd_cnt[i] <= rd_cnt[i] + 16'd1;
      end
    end
  end

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.fifo_num  = '0;
    bus.burst_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns the number of negedges until burst_req is seen (0 = already high), or -1.
  task automatic wait_req(input int limit, output int lat);
    lat = -1;
    for (int k = 0; k <= limit; k++) begin
      if (bus.burst_req === 1'b1) begin
        lat = k;
        break;
      end
      if (k < limit) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " rd_en"},       bus.fifo_rd_en,  0);
    check({tag, " burst_req"},   bus.burst_req,   0);
    check({tag, " burst_ch"},    bus.burst_ch,    0);
    check({tag, " out_valid"},   bus.out_valid,   0);
    check({tag, " out_last"},    bus.out_last,    0);
    check({tag, " out_data"},    bus.out_data,    0);
    check({tag, " burst_done"},  bus.burst_done,  0);
    check({tag, " burst_abort"}, bus.burst_abort, 0);
  endtask

  // Full burst: ack ack_dly cycles after req is seen, then observe ack+1 .. ack+514.
  task automatic do_burst(input string tag, input int exp_ch, input int ack_dly,
                          input logic [15:0] first_word, output int req_cyc);
    int lat, n_rd, n_val, n_last, n_done, first_val, last_pos, done_pos;
    int bad_rd, bad_data, bad_ch, bad_req;
    logic [15:0] exp_word;
    req_cyc = -1;
    wait_req(40, lat);
    check({tag, " req seen"}, lat >= 0, 1);
    if (lat < 0) return;
    req_cyc = cyc_cnt;
    check({tag, " burst_ch"}, bus.burst_ch, exp_ch);
    repeat (ack_dly) @(negedge clk);
    check({tag, " req held until ack"}, bus.burst_req, 1);
    bus.burst_ack = 1'b1;
    @(negedge clk);
    bus.burst_ack = 1'b0;
    n_rd = 0; n_val = 0; n_last = 0; n_done = 0;
    first_val = -1; last_pos = -1; done_pos = -1;
    bad_rd = 0; bad_data = 0; bad_ch = 0; bad_req = 0;
    exp_word = first_word;
    for (int t = 1; t <= BURST_LEN + 2; t++) begin
      if (bus.fifo_rd_en != 4'b0) begin
        n_rd++;
        if (bus.fifo_rd_en != 4'(1 << exp_ch)) bad_rd++;
      end
      if (bus.out_valid) begin
        if (first_val < 0) first_val = t;
        n_val++;
        if (bus.out_data != exp_word) bad_data++;
        exp_word = exp_word + 16'd1;
      end
      if (bus.out_last) begin
        n_last++;
        last_pos = t;
      end
      if (bus.burst_done) begin
        n_done++;
        done_pos = t;
      end
      if (bus.burst_ch != 2'(exp_ch)) bad_ch++;
      if (bus.burst_req) bad_req++;
      @(negedge clk);
    end
    check({tag, " rd_en pulses"},        n_rd,      BURST_LEN);
    check({tag, " rd_en wrong channel"}, bad_rd,    0);
    check({tag, " out_valid words"},     n_val,     BURST_LEN);
    check({tag, " first word cycle"},    first_val, 2);
    check({tag, " out_last count"},      n_last,    1);
    check({tag, " out_last cycle"},      last_pos,  BURST_LEN + 1);
    check({tag, " burst_done count"},    n_done,    1);
    check({tag, " burst_done cycle"},    done_pos,  BURST_LEN + 2);
    check({tag, " data errors"},         bad_data,  0);
    check({tag, " burst_ch changes"},    bad_ch,    0);
    check({tag, " req during xfer"},     bad_req,   0);
  endtask

  typedef struct {
    logic [NUM_CH*CNT_W-1:0] num;
    bit                      exp_req;
    int                      exp_ch;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat, rc, prev, n_val, k, rd_seen, drops;
    int          rr_order [5];
    logic [15:0] rr_base  [5];

    vecs[0] = '{num: {11'd0,    11'd0,   11'd0,   11'd514},  exp_req: 1'b1, exp_ch: 0};
    vecs[1] = '{num: {11'd0,    11'd513, 11'd0,   11'd0},    exp_req: 1'b0, exp_ch: 0};
    vecs[2] = '{num: {11'd0,    11'd514, 11'd0,   11'd0},    exp_req: 1'b1, exp_ch: 2};
    vecs[3] = '{num: {11'd2047, 11'd0,   11'd0,   11'd2047}, exp_req: 1'b1, exp_ch: 3};
    vecs[4] = '{num: {11'd0,    11'd0,   11'd514, 11'd514},  exp_req: 1'b1, exp_ch: 1};
    vecs[5] = '{num: {11'd0,    11'd0,   11'd0,   11'd0},    exp_req: 1'b0, exp_ch: 0};
    vecs[6] = '{num: {11'd513,  11'd513, 11'd513, 11'd513},  exp_req: 1'b0, exp_ch: 0};
    vecs[7] = '{num: {11'd1200, 11'd0,   11'd0,   11'd0},    exp_req: 1'b1, exp_ch: 3};
    vecs[8] = '{num: {11'd0,    11'd600, 11'd0,   11'd600},  exp_req: 1'b1, exp_ch: 2};

    bus.fifo_num  = '0;
    bus.burst_ack = 1'b0;

    // Reset state, observed while reset is held.
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // Eligibility and arbitration from a fresh reset (rr_ptr = 0).
    for (int v = 0; v < 9; v++) begin
      apply_reset();
      bus.fifo_num = vecs[v].num;
      wait_req(6, lat);
      check($sformatf("vec%0d req latency", v), lat, vecs[v].exp_req ? 2 : -1);
      check($sformatf("vec%0d burst_ch", v), bus.burst_ch, vecs[v].exp_ch);
    end

    // Threshold edge: 513 never requests, 514 requests two cycles after the change.
    apply_reset();
    bus.fifo_num = {11'd0, 11'd513, 11'd0, 11'd0};
    wait_req(10, lat);
    check("threshold 513 no req", lat, -1);
    bus.fifo_num = {11'd0, 11'd514, 11'd0, 11'd0};
    wait_req(6, lat);
    check("threshold 514 req latency", lat, 2);
    check("threshold 514 burst_ch", bus.burst_ch, 2);

    // Single channel, ack three cycles after req.
    apply_reset();
    bus.fifo_num = {11'd0, 11'd0, 11'd0, 11'd514};
    do_burst("single ch0", 0, 3, 16'h1000, rc);

    // Data integrity on channel 3 (pattern 0x0000..0x01FF).
    apply_reset();
    bus.fifo_num = {11'd514, 11'd0, 11'd0, 11'd0};
    do_burst("data ch3", 3, 0, 16'h0000, rc);

    // Round-robin with every channel eligible; engine acks one cycle after req.
    rr_order = '{1, 2, 3, 0, 1};
    rr_base  = '{16'h2000, 16'h3000, 16'h0000, 16'h1000, 16'h2200};
    apply_reset();
    bus.fifo_num = {4{11'd600}};
    prev = -1;
    for (int b = 0; b < 5; b++) begin
      do_burst($sformatf("rr burst%0d", b), rr_order[b], 1, rr_base[b], rc);
      if (b > 0) check($sformatf("rr spacing %0d", b), rc - prev, BURST_LEN + 4);
      prev = rc;
    end

    // Reset at word 100 of the next burst (channel 2): rr_ptr must return to 0.
    wait_req(20, lat);
    check("mid-reset burst_ch", bus.burst_ch, 2);
    bus.burst_ack = 1'b1;
    @(negedge clk);
    bus.burst_ack = 1'b0;
    n_val = 0;
    k = 0;
    while (n_val < 100 && k < 200) begin
      if (bus.out_valid) n_val++;
      if (n_val < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("mid-reset words seen", n_val, 100);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid-xfer reset");
    reset = 1'b0;
    wait_req(6, lat);
    check("post-reset req latency", lat, 2);
    check("post-reset burst_ch", bus.burst_ch, 1);

`ifdef FIFO_SCHED_TIMEOUT_EN
    // No ack: abort TIMEOUT cycles after req rises, no reads, next grant moves on.
    apply_reset();
    bus.fifo_num = {4{11'd600}};
    wait_req(20, lat);
    check("timeout req seen", lat >= 0, 1);
    check("timeout burst_ch", bus.burst_ch, 1);
    k = 0;
    rd_seen = 0;
    while (bus.burst_abort !== 1'b1 && k < TIMEOUT + 100) begin
      @(negedge clk);
      k++;
      if (bus.fifo_rd_en != 4'b0) rd_seen++;
    end
    check("timeout abort cycle", k, TIMEOUT);
    check("timeout req dropped", bus.burst_req, 0);
    check("timeout no reads", rd_seen, 0);
    @(negedge clk);
    check("timeout abort one cycle", bus.burst_abort, 0);
    wait_req(20, lat);
    check("timeout next grant", bus.burst_ch, 2);
`else
    // No ack for a long time: REQ holds, no abort, no reads; a late ack still completes.
    apply_reset();
    bus.fifo_num = {11'd0, 11'd0, 11'd0, 11'd600};
    wait_req(20, lat);
    check("hold req seen", lat >= 0, 1);
    drops = 0;
    rd_seen = 0;
    for (int c = 0; c < TIMEOUT + 76; c++) begin
      @(negedge clk);
      if (bus.burst_req !== 1'b1 || bus.burst_abort !== 1'b0) drops++;
      if (bus.fifo_rd_en != 4'b0) rd_seen++;
    end
    check("hold req/abort stable", drops, 0);
    check("hold no reads", rd_seen, 0);
    do_burst("late ack ch0", 0, 0, 16'h1000, rc);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
